line_clear_ctrl: RTL and testbench

Sequencer that owns the playfield grid's single cell port during line-clear. On a start pulse it scans the 20×10 grid bottom-up, detects full rows and collapses each one by copying every row above it down by one. It then zeroes the top row and reports the number of lines removed. It sits between the game FSM and the grid memory. While `busy` is high, the top-level port mux routes the grid's `x`/`y`/read/write signals from this block.

---
 rtl/tetris_pkg.sv | 19 +
 rtl/line_clear_ctrl_if.sv | 25 ++
 rtl/line_clear_ctrl.sv | 150 +++++++++++++++
 tb/tb_line_clear_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared playfield constants and line-clear state encoding
// Contents: ROWS/COLS grid geometry, XW/YW cell address widths, lcc_state_t.
package tetris_pkg;

  localparam int ROWS = 20;  // row 0 is the top, ROWS-1 the bottom
  localparam int COLS = 10;
  localparam int XW   = 4;
  localparam int YW   = 5;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SHIFT_RD,
    SHIFT_WR,
    CLEAR_TOP,
    DONE
  } lcc_state_t;

endpackage

// File: rtl/line_clear_ctrl_if.sv
// rtl/line_clear_ctrl_if.sv - single-cell grid port driven by the line-clear sequencer
// Signals: x/y cell address, rd_en/wr_en strobes, wr_data cell value written,
//   rd_data cell value returned combinationally for the current x/y.
// Modports: master (sequencer side), slave (grid memory side).
interface line_clear_ctrl_if;
  import tetris_pkg::*;

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          rd_en;
  logic          wr_en;
  logic          wr_data;
  logic          rd_data;

  modport master (
    output x, y, rd_en, wr_en, wr_data,
    input  rd_data
  );

  modport slave (
    input  x, y, rd_en, wr_en, wr_data,
    output rd_data
  );

endinterface

// File: rtl/line_clear_ctrl.sv
// rtl/line_clear_ctrl.sv - bottom-up full-row detect and collapse sequencer
// Ports: clk; rst_n (asynchronous, active-low); start (one-cycle request, taken in IDLE only);
//   busy (run in progress, including the done cycle); done (one-cycle completion pulse);
//   lines_cleared (rows removed by the last run, held until the next accepted start);
//   grid (master side of the single cell port).
module line_clear_ctrl
  import tetris_pkg::*;
#(
  parameter int CW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [CW-1:0]     lines_cleared,
  line_clear_ctrl_if.master grid
);

  localparam logic [XW-1:0] COL_LAST = XW'(COLS - 1);
  localparam logic [YW-1:0] ROW_LAST = YW'(ROWS - 1);
  localparam logic [CW-1:0] LC_MAX   = CW'(ROWS);

  lcc_state_t    state, state_n;
  logic [YW-1:0] row, row_n;   // row being scanned
  logic [YW-1:0] r, r_n;       // destination row of the current copy pass
  logic [XW-1:0] col, col_n;
  logic          hold, hold_n; // cell read in SHIFT_RD, written in SHIFT_WR
  logic [CW-1:0] lc_n;

  logic [XW-1:0] x_c;
  logic [YW-1:0] y_c;
  logic          rd_en_c, wr_en_c, wr_data_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      row           <= '0;
      r             <= '0;
      col           <= '0;
      hold          <= 1'b0;
      lines_cleared <= '0;
    end else begin
      state         <= state_n;
      row           <= row_n;
      r             <= r_n;
      col           <= col_n;
      hold          <= hold_n;
      lines_cleared <= lc_n;
    end
  end

  always_comb begin
    state_n   = state;
    row_n     = row;
    r_n       = r;
    col_n     = col;
    hold_n    = hold;
    lc_n      = lines_cleared;
    x_c       = '0;
    y_c       = '0;
    rd_en_c   = 1'b0;
    wr_en_c   = 1'b0;
    wr_data_c = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          row_n   = ROW_LAST;
          col_n   = '0;
          lc_n    = '0;
          state_n = CHECK;
        end
      end

      CHECK: begin
        x_c     = col;
        y_c     = row;
        rd_en_c = 1'b1;
        if (!grid.rd_data) begin
          // First empty cell ends this row; move up or finish at the top.
          col_n = '0;
          if (row == '0) state_n = DONE;
          else           row_n   = row - 1'b1;
        end else if (col != COL_LAST) begin
          col_n = col + 1'b1;
        end else begin
          r_n     = row;
          col_n   = '0;
          state_n = (row == '0) ? CLEAR_TOP : SHIFT_RD;
        end
      end

      SHIFT_RD: begin
        x_c     = col;
        y_c     = r - 1'b1;
        rd_en_c = 1'b1;
        hold_n  = grid.rd_data;
        state_n = SHIFT_WR;
      end

      SHIFT_WR: begin
        x_c       = col;
        y_c       = r;
        wr_en_c   = 1'b1;
        wr_data_c = hold;
        if (col != COL_LAST) begin
          col_n   = col + 1'b1;
          state_n = SHIFT_RD;
        end else begin
          col_n   = '0;
          r_n     = r - 1'b1;
          // Row 1 was just copied into; only the top row is left to blank.
          state_n = (r == YW'(1)) ? CLEAR_TOP : SHIFT_RD;
        end
      end

      CLEAR_TOP: begin
        x_c     = col;
        y_c     = '0;
        wr_en_c = 1'b1;
        if (col != COL_LAST) begin
          col_n = col + 1'b1;
        end else begin
          col_n   = '0;
          if (lines_cleared != LC_MAX) lc_n = lines_cleared + 1'b1;
          // row is left unchanged so the row that dropped into it is scanned again.
          state_n = CHECK;
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign busy         = (state != IDLE);
  assign done         = (state == DONE);
  assign grid.x       = x_c;
  assign grid.y       = y_c;
  assign grid.rd_en   = rd_en_c;
  assign grid.wr_en   = wr_en_c;
  assign grid.wr_data = wr_data_c;

endmodule

// File: tb/tb_line_clear_ctrl.sv
// tb/tb_line_clear_ctrl.sv - self-checking bench for line_clear_ctrl
module tb_line_clear_ctrl;
  import tetris_pkg::*;

  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy;
  logic          done;
  logic [CW-1:0] lines_cleared;

  line_clear_ctrl_if grid_port ();

  line_clear_ctrl #(.CW(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .lines_cleared (lines_cleared),
    .grid          (grid_port)
  );

  always #5 clk = ~clk;

  // Grid memory: bit c of a row word is column c.
  logic [COLS-1:0] mem       [ROWS];
  logic [COLS-1:0] init_rows [ROWS];
  logic [COLS-1:0] m_rows    [ROWS];

  int m_lines;
  int exp_done;
  int cyc;
  int tail;
  int wr_count;
  int checks = 0;
  int failures = 0;
  bit run_active = 1'b0;

  assign grid_port.rd_data = (int'(grid_port.x) < COLS && int'(grid_port.y) < ROWS)
                             ? mem[grid_port.y][grid_port.x] : 1'b0;

  always @(posedge clk) begin
    if (grid_port.wr_en && int'(grid_port.x) < COLS && int'(grid_port.y) < ROWS) begin
      mem[grid_port.y][grid_port.x] = grid_port.wr_data;
      wr_count = wr_count + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks = checks + 1;
    if (act !== req) begin
      failures = failures + 1;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Per-cycle comparison against the model's expected completion cycle.
  always @(negedge clk) begin
    if (run_active) begin
      cyc = cyc + 1;
      check("rd_wr_exclusive", 32'(grid_port.rd_en & grid_port.wr_en), 32'd0);
      if (grid_port.rd_en || grid_port.wr_en) begin
        check("x_in_range", 32'(int'(grid_port.x) < COLS), 32'd1);
        check("y_in_range", 32'(int'(grid_port.y) < ROWS), 32'd1);
      end else begin
        check("x_zero_when_idle", 32'(grid_port.x), 32'd0);
        check("y_zero_when_idle", 32'(grid_port.y), 32'd0);
      end
      check("busy", 32'(busy), 32'(cyc <= exp_done));
      check("done", 32'(done), 32'(cyc == exp_done));
      if (cyc >= exp_done + tail) run_active = 1'b0;
    end
  end

  // Row-level model: scan from the bottom, a full row costs its check pass,
  // one read+write per cell above it, and the top-row blanking, then is re-scanned.
  task automatic model_run();
    int y;
    int n;
    int fz;
    for (int i = 0; i < ROWS; i++) m_rows[i] = init_rows[i];
    m_lines = 0;
    n = 0;
    y = ROWS - 1;
    while (y >= 0) begin
      if (m_rows[y] == {COLS{1'b1}}) begin
        n = n + COLS + 2 * COLS * y + COLS;
        if (m_lines < ROWS) m_lines = m_lines + 1;
        for (int k = y; k > 0; k--) m_rows[k] = m_rows[k-1];
        m_rows[0] = '0;
      end else begin
        fz = 0;
        while (fz < COLS && m_rows[y][fz]) fz = fz + 1;
        n = n + fz + 1;
        y = y - 1;
      end
    end
    exp_done = n + 1;
  endtask

  task automatic clear_init();
    for (int i = 0; i < ROWS; i++) init_rows[i] = '0;
  endtask

  task automatic load_grid();
    for (int i = 0; i < ROWS; i++) mem[i] = init_rows[i];
    wr_count = 0;
  endtask

  task automatic launch(input int t);
    tail = t;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    cyc = 0;
    run_active = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_finish(input string name);
    int guard;
    guard = 0;
    while (run_active && guard < exp_done + 100) begin
      @(negedge clk);
      guard = guard + 1;
    end
    check({name, "_timeout"}, 32'(run_active), 32'd0);
    run_active = 1'b0;
  endtask

  task automatic check_result(input string name);
    check({name, "_lines_cleared"}, 32'(lines_cleared), 32'(m_lines));
    for (int i = 0; i < ROWS; i++)
      check($sformatf("%s_row%0d", name, i), 32'(mem[i]), 32'(m_rows[i]));
  endtask

  task automatic run_case(input string name, input int lit_lines, input int lit_done);
    load_grid();
    model_run();
    check({name, "_model_lines"}, 32'(m_lines), 32'(lit_lines));
    check({name, "_model_done_cycle"}, 32'(exp_done), 32'(lit_done));
    launch(3);
    wait_finish(name);
    check_result(name);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_done"}, 32'(done), 32'd0);
    check({name, "_lines_cleared"}, 32'(lines_cleared), 32'd0);
    check({name, "_rd_en"}, 32'(grid_port.rd_en), 32'd0);
    check({name, "_wr_en"}, 32'(grid_port.wr_en), 32'd0);
    check({name, "_wr_data"}, 32'(grid_port.wr_data), 32'd0);
    check({name, "_x"}, 32'(grid_port.x), 32'd0);
    check({name, "_y"}, 32'(grid_port.y), 32'd0);
  endtask

  initial begin
    bit saw;
    clear_init();
    load_grid();
    exp_done = 0;
    tail = 0;
    cyc = 0;

    repeat (3) @(negedge clk);
    check_all_zero("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("after_reset");

    // Empty grid: one check per row, no writes at all.
    clear_init();
    run_case("empty", 0, 21);
    check("empty_writes", 32'(wr_count), 32'd0);

    // Bottom row full only.
    clear_init();
    init_rows[19] = '1;
    run_case("row19", 1, 421);

    // Four full rows under a partial one: partial row ends up at the bottom.
    clear_init();
    for (int i = 16; i < 20; i++) init_rows[i] = '1;
    init_rows[15] = 10'b0000000101;
    run_case("rows16_19", 4, 1622);
    check("rows16_19_bottom_literal", 32'(mem[19]), 32'h005);

    // Only the top row full: straight to top-row blanking.
    clear_init();
    init_rows[0] = '1;
    run_case("row0", 1, 41);
    check("row0_writes", 32'(wr_count), 32'd10);

    // Whole grid full: count reaches ROWS exactly.
    clear_init();
    for (int i = 0; i < ROWS; i++) init_rows[i] = '1;
    run_case("full", 20, 8021);

    // start pulsed again mid-shift is ignored; one done only, long tail watches for a second.
    clear_init();
    init_rows[19] = '1;
    init_rows[18] = 10'b1111100000;
    load_grid();
    model_run();
    launch(40);
    repeat (30) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_finish("restart");
    check_result("restart");

    // Reset pulsed mid-shift: everything back to zero at once, no done afterwards.
    clear_init();
    init_rows[19] = '1;
    load_grid();
    model_run();
    launch(3);
    repeat (14) @(negedge clk);
    run_active = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done || busy) saw = 1'b1;
    end
    check("mid_reset_no_done", 32'(saw), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
